immediate_unit: RTL and testbench

Parametrised, pipelined immediate generator for the decode stage. It accepts an instruction word and an immediate-format select over a valid/ready handshake, and produces an XLEN-wide immediate one cycle later. It supports I/S/B/U/J plus CSR-uimm and shift-amount formats, and flags illegal selects. A 2-entry output queue decouples decode from a stalled execute stage and lets the block sustain 1 op/cycle under backpressure. A flush input supports branch redirect.

---
 rtl/zeptron_pkg.sv | 19 +
 rtl/imm_decode.sv | 45 ++++
 rtl/immediate_unit.sv | 112 +++++++++++
 tb/tb_immediate_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeptron_pkg.sv
// zeptron_pkg: shared decode-stage definitions.
//   imm_op_e     : immediate format select carried on in_op
//   XLEN_DEFAULT : default datapath width for decode-stage blocks
package zeptron_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_Z    = 3'd5,
      IMM_SH   = 3'd6,
      IMM_RSVD = 3'd7
   } imm_op_e;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction from an instruction word.
// Ports:
//   instr   in  32    instruction word
//   op      in  3     format select (imm_op_e encoding)
//   imm     out XLEN  finished immediate (sign- or zero-extended)
//   illegal out 1     op is the reserved encoding; imm is 0 in that case
module imm_decode
   import zeptron_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      op,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   // The opcode field never contributes to an immediate.
   logic w_unused_opcode;
   assign w_unused_opcode = ^instr[6:0];

   // Signed size casts sign-extend from instr[31] to XLEN for every
   // signed format; unsigned casts zero-extend the CSR uimm and shamt.
   always_comb begin
      imm     = '0;
      illegal = 1'b0;
      case (imm_op_e'(op))
         IMM_I:  imm = XLEN'($signed(instr[31:20]));
         IMM_S:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         IMM_B:  imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                      instr[11:8], 1'b0}));
         IMM_U:  imm = XLEN'($signed({instr[31:12], 12'b0}));
         IMM_J:  imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                      instr[30:21], 1'b0}));
         IMM_Z:  imm = XLEN'(instr[19:15]);
         // RV64 shifts take a 6-bit shamt, RV32 only 5 bits.
         IMM_SH: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
         default: begin
            imm     = '0;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/immediate_unit.sv
// immediate_unit: pipelined immediate generator with a small output queue.
// Immediates are decoded before the queue write, so entries hold finished
// values. Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 synchronous; drops every queued entry
//   in_valid/in_ready     input handshake (in_ready from registered count only)
//   in_instr, in_op       instruction word and format select
//   in_tag                sideband tag passed through unchanged
//   out_valid/out_ready   output handshake for the head entry
//   out_imm, out_tag      head entry immediate and tag (0 when empty)
//   out_illegal           head entry carried the reserved format select
module immediate_unit
   import zeptron_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int TAG_W = 5,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
      $error("immediate_unit: XLEN must be 32 or 64");
   end
   if (DEPTH < 2 || DEPTH > 4) begin : g_bad_depth
      $error("immediate_unit: DEPTH must be 2..4");
   end

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [XLEN-1:0]  w_imm;
   logic             w_illegal;
   logic             w_push;
   logic             w_pop;

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic [XLEN-1:0]  r_imm     [DEPTH];
   logic [TAG_W-1:0] r_tag     [DEPTH];
   logic             r_illegal [DEPTH];

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr   (in_instr),
      .op      (in_op),
      .imm     (w_imm),
      .illegal (w_illegal)
   );

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign in_ready  = (r_count < CNT_W'(DEPTH)) && !flush;
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready;
   // A pop presented during flush is not consumed: flush wins.
   assign w_pop     = out_valid && out_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Storage needs no reset: the outputs are masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_imm[r_wr_ptr]     <= w_imm;
         r_tag[r_wr_ptr]     <= in_tag;
         r_illegal[r_wr_ptr] <= w_illegal;
      end
   end

   assign out_imm     = out_valid ? r_imm[r_rd_ptr]     : '0;
   assign out_tag     = out_valid ? r_tag[r_rd_ptr]     : '0;
   assign out_illegal = out_valid ? r_illegal[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_immediate_unit.sv
// Self-checking bench for immediate_unit. Two instances (XLEN=32 and 64)
// receive identical stimulus; each has its own scoreboard queue.
module tb_immediate_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [2:0]  in_op;
   logic [4:0]  in_tag;
   logic        out_ready;

   logic        in_ready32, out_valid32, out_illegal32;
   logic [31:0] out_imm32;
   logic [4:0]  out_tag32;
   logic        in_ready64, out_valid64, out_illegal64;
   logic [63:0] out_imm64;
   logic [4:0]  out_tag64;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [63:0] imm;
      logic [4:0]  tag;
      logic        ill;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];

   always #5 clk = ~clk;

   immediate_unit #(.XLEN(32), .TAG_W(5), .DEPTH(2)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32),
      .in_instr(in_instr), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid32), .out_ready(out_ready),
      .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_illegal32)
   );

   immediate_unit #(.XLEN(64), .TAG_W(5), .DEPTH(2)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready),
      .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Reference immediate model, written from the format table.
   function automatic exp_t ref_dec(input logic [31:0] ins, input logic [2:0] op,
                                    input logic [4:0] tag, input int xlen);
      exp_t e;
      logic signed [63:0] v;
      e.ill = 1'b0;
      case (op)
         3'd0: v = $signed(ins[31:20]);
         3'd1: v = $signed({ins[31:25], ins[11:7]});
         3'd2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
         3'd3: v = $signed({ins[31:12], 12'h000});
         3'd4: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
         3'd5: v = {59'd0, ins[19:15]};
         3'd6: v = (xlen == 64) ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
         default: begin
            v     = '0;
            e.ill = 1'b1;
         end
      endcase
      if (xlen == 32) v[63:32] = '0;
      e.imm = v;
      e.tag = tag;
      return e;
   endfunction

   // Scoreboard: pop/compare on every consumed head, push on every accept.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (out_valid32 && out_ready && !flush) begin
            if (q32.size() == 0) begin
               check("sb32_unexpected_out", 64'd1, 64'd0);
            end else begin
               e = q32.pop_front();
               check("sb32_imm", {32'd0, out_imm32}, e.imm);
               check("sb32_tag", {59'd0, out_tag32}, {59'd0, e.tag});
               check("sb32_ill", {63'd0, out_illegal32}, {63'd0, e.ill});
            end
         end
         if (out_valid64 && out_ready && !flush) begin
            if (q64.size() == 0) begin
               check("sb64_unexpected_out", 64'd1, 64'd0);
            end else begin
               e = q64.pop_front();
               check("sb64_imm", out_imm64, e.imm);
               check("sb64_tag", {59'd0, out_tag64}, {59'd0, e.tag});
               check("sb64_ill", {63'd0, out_illegal64}, {63'd0, e.ill});
            end
         end
         if (in_valid && in_ready32 && !flush) q32.push_back(ref_dec(in_instr, in_op, in_tag, 32));
         if (in_valid && in_ready64 && !flush) q64.push_back(ref_dec(in_instr, in_op, in_tag, 64));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [2:0] op, input logic [4:0] tag);
      in_valid = 1'b1;
      in_instr = ins;
      in_op    = op;
      in_tag   = tag;
   endtask

   task automatic check_idle(input string name);
      check({name, "_valid32"}, {63'd0, out_valid32}, 64'd0);
      check({name, "_valid64"}, {63'd0, out_valid64}, 64'd0);
      check({name, "_imm32"}, {32'd0, out_imm32}, 64'd0);
      check({name, "_imm64"}, out_imm64, 64'd0);
      check({name, "_tag"}, {59'd0, out_tag32 | out_tag64}, 64'd0);
      check({name, "_ill"}, {62'd0, out_illegal32, out_illegal64}, 64'd0);
      check({name, "_ready"}, {62'd0, in_ready32, in_ready64}, 64'd3);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_instr = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
      #1;
      check_idle("reset");
      step();
      step();
      rst = 1'b0;

      // 1: I/B/J back-to-back on XLEN=32
      drive(32'hFFF00093, 3'd0, 5'd1);
      step();
      check("t1_imm_I", {32'd0, out_imm32}, 64'hFFFFFFFF);
      check("t1_ill", {63'd0, out_illegal32}, 64'd0);
      drive(32'hFE000EE3, 3'd2, 5'd2);
      step();
      check("t1_imm_B", {32'd0, out_imm32}, 64'hFFFFFFFC);
      drive(32'hFF9FF06F, 3'd4, 5'd3);
      step();
      check("t1_imm_J", {32'd0, out_imm32}, 64'hFFFFFFF8);
      check("t1_imm_J64", out_imm64, 64'hFFFFFFFFFFFFFFF8);
      in_valid = 1'b0;
      step();

      // 2: U/Z/SH on XLEN=64 (and shamt width on XLEN=32)
      drive(32'h80000037, 3'd3, 5'd4);
      step();
      check("t2_U_neg", out_imm64, 64'hFFFFFFFF80000000);
      drive(32'h123450B7, 3'd3, 5'd5);
      step();
      check("t2_U_pos", out_imm64, 64'h0000000012345000);
      drive(32'h000F8073, 3'd5, 5'd6);
      step();
      check("t2_Z", out_imm64, 64'h1F);
      drive(32'h03F0D093, 3'd6, 5'd7);
      step();
      check("t2_SH64", out_imm64, 64'h3F);
      check("t2_SH32", {32'd0, out_imm32}, 64'h1F);
      in_valid = 1'b0;
      step();

      // 3: backpressure, queue fills at two entries
      out_ready = 1'b0;
      drive(32'h00100093, 3'd0, 5'd1);
      step();
      check("t3_ready_cnt1", {63'd0, in_ready32}, 64'd1);
      drive(32'h00200093, 3'd0, 5'd2);
      step();
      check("t3_ready_full", {62'd0, in_ready32, in_ready64}, 64'd0);
      check("t3_head_tag", {59'd0, out_tag32}, 64'd1);
      drive(32'h00300093, 3'd0, 5'd3);
      for (int i = 0; i < 2; i++) begin
         step();
         check("t3_held_tag", {59'd0, out_tag32}, 64'd1);
         check("t3_held_imm", {32'd0, out_imm32}, 64'd1);
         check("t3_held_ready", {63'd0, in_ready32}, 64'd0);
      end
      out_ready = 1'b1;
      #1;
      check("t3_full_pop_ready", {63'd0, in_ready32}, 64'd0);
      step();
      check("t3_order2", {59'd0, out_tag32}, 64'd2);
      check("t3_ready_after_pop", {63'd0, in_ready32}, 64'd1);
      step();
      in_valid = 1'b0;
      check("t3_order3", {59'd0, out_tag32}, 64'd3);
      step();
      check("t3_drained", {63'd0, out_valid32}, 64'd0);

      // 4: push and pop together at count==1
      out_ready = 1'b0;
      drive(32'h00A00093, 3'd0, 5'd10);
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(32'h00B00093 + (i << 20), 3'd0, 5'(11 + i));
         check("t4_ready", {62'd0, in_ready32, in_ready64}, 64'd3);
         check("t4_tag", {59'd0, out_tag64}, 64'(10 + i));
         step();
      end
      in_valid = 1'b0;
      check("t4_last_tag", {59'd0, out_tag32}, 64'd20);
      step();
      check("t4_drained", {63'd0, out_valid64}, 64'd0);

      // 5: flush with two entries, then with one entry
      out_ready = 1'b0;
      drive(32'h01500093, 3'd0, 5'd21);
      step();
      drive(32'h01600093, 3'd0, 5'd22);
      step();
      drive(32'h01700093, 3'd0, 5'd23);
      flush = 1'b1;
      out_ready = 1'b1;
      #1;
      check("t5_flush_ready2", {62'd0, in_ready32, in_ready64}, 64'd0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      q32.delete(); q64.delete();
      check("t5_flushed_valid", {62'd0, out_valid32, out_valid64}, 64'd0);
      step();
      check("t5_no_accept", {62'd0, out_valid32, out_valid64}, 64'd0);
      out_ready = 1'b0;
      drive(32'h01800093, 3'd0, 5'd24);
      step();
      drive(32'h01900093, 3'd0, 5'd25);
      flush = 1'b1;
      #1;
      check("t5_flush_ready1", {62'd0, in_ready32, in_ready64}, 64'd0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      q32.delete(); q64.delete();
      check("t5_flushed1_valid", {62'd0, out_valid32, out_valid64}, 64'd0);
      step();
      check("t5_no_accept1", {62'd0, out_valid32, out_valid64}, 64'd0);

      // 6: reserved op, then async reset with two entries queued
      out_ready = 1'b1;
      drive(32'hFFFFFFFF, 3'd7, 5'd9);
      step();
      in_valid = 1'b0;
      check("t6_rsvd_imm", out_imm64 | {32'd0, out_imm32}, 64'd0);
      check("t6_rsvd_ill", {62'd0, out_illegal32, out_illegal64}, 64'd3);
      check("t6_rsvd_tag", {59'd0, out_tag64}, 64'd9);
      step();
      out_ready = 1'b0;
      drive(32'h81A00093, 3'd0, 5'd26);
      step();
      drive(32'h01B00093, 3'd0, 5'd27);
      step();
      in_valid = 1'b0;
      check("t6_queued", {62'd0, out_valid32, out_valid64}, 64'd3);
      #2;
      rst = 1'b1;
      #1;
      q32.delete(); q64.delete();
      check_idle("t6_async_rst");
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      check_idle("t6_after_rst");

      check("end_sb32_empty", 64'(q32.size()), 64'd0);
      check("end_sb64_empty", 64'(q64.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
